xc_aessub: RTL and testbench

XC_AESSUB -- requirements
Module: xc_aessub

---
 rtl/xc_aessub_if.sv | 12 +
 rtl/xc_aessub.sv | 159 +++++++++++++++
 tb/tb_xc_aessub.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xc_aessub_if.sv
// Request/response bundle between the core and the AES column S-box unit.
interface xc_aessub_if;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] result;

    modport master (output valid, rs1, rs2, enc, input ready, result);
    modport slave  (input valid, rs1, rs2, enc, output ready, result);
endinterface

// File: rtl/xc_aessub.sv
// AES column SubBytes/InvSubBytes unit: one shared S-box iterated over four bytes.
// Define XC_AESSUB_FAST_EN for the single-cycle build with four parallel S-boxes.
module xc_aessub (
    input  logic         clock,
    input  logic         reset,
    xc_aessub_if.slave   bus
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
        logic [7:0] inv;
        inv = gf_inv(fwd ? x : inv_affine(x));
        return fwd ? fwd_affine(inv) : inv;
    endfunction

    // Only the two low bytes of rs1 and two high bytes of rs2 form the column.
    logic [31:0] column;
    logic        unused_bits;
    assign column      = {bus.rs2[31:16], bus.rs1[15:0]};
    assign unused_bits = ^{bus.rs1[31:16], bus.rs2[15:0]};

`ifdef XC_AESSUB_FAST_EN

    logic [31:0] fast_result;
    logic        unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign fast_result[gi*8 +: 8] = sbox(column[gi*8 +: 8], bus.enc);
        end
    endgenerate

    assign bus.ready  = bus.valid;
    assign bus.result = bus.valid ? fast_result : 32'h0;

`else

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [31:0] operand_reg, operand_next;
    logic        enc_reg, enc_next;
    logic [31:0] result_reg, result_next;
    logic        ready_next;
    logic [7:0]  op_byte;
    logic [7:0]  sub_byte;

    assign op_byte  = operand_reg[{idx_reg, 3'b000} +: 8];
    assign sub_byte = sbox(op_byte, enc_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= 2'd0;
            operand_reg <= 32'h0;
            enc_reg     <= 1'b0;
            result_reg  <= 32'h0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            operand_reg <= operand_next;
            enc_reg     <= enc_next;
            result_reg  <= result_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        operand_next = operand_reg;
        enc_next     = enc_reg;
        result_next  = result_reg;
        ready_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.valid) begin
                    operand_next = column;
                    enc_next     = bus.enc;
                    idx_next     = 2'd0;
                    result_next  = 32'h0;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (!bus.valid) begin
                    state_next   = IDLE;
                    idx_next     = 2'd0;
                    operand_next = 32'h0;
                    enc_next     = 1'b0;
                    result_next  = 32'h0;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (idx_reg == i[1:0]) result_next[i*8 +: 8] = sub_byte;
                    end
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) state_next = DONE;
                end
            end
            DONE: begin
                // Completion and abort both return to IDLE with cleared state;
                // only a still-valid request sees ready.
                ready_next   = bus.valid;
                state_next   = IDLE;
                idx_next     = 2'd0;
                operand_next = 32'h0;
                enc_next     = 1'b0;
                result_next  = 32'h0;
            end
            default: begin
                state_next   = IDLE;
                idx_next     = 2'd0;
                operand_next = 32'h0;
                enc_next     = 1'b0;
                result_next  = 32'h0;
            end
        endcase
    end

    assign bus.ready  = ready_next;
    assign bus.result = ready_next ? result_reg : 32'h0;

`endif

endmodule

// File: tb/tb_xc_aessub.sv
// Directed self-checking bench for xc_aessub (iterative build): latency, abort, reset, back-to-back.
module tb_xc_aessub;

    logic clock = 1'b0;
    logic reset;
    xc_aessub_if bus ();

    xc_aessub dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic        tv_enc [0:3];
    logic [31:0] tv_rs1 [0:3];
    logic [31:0] tv_rs2 [0:3];
    logic [31:0] tv_exp [0:3];

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        bus.valid = 1'b1;
        bus.enc   = 1'b1;
        bus.rs1   = 32'hffffffff;
        bus.rs2   = 32'hffffffff;
        reset     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (bus.ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready cycle %0d: got %b want 0", k, bus.ready);
            end
            checks++;
            if (bus.result !== 32'h0) begin
                errors++;
                $display("FAIL reset_result cycle %0d: got %h want 00000000", k, bus.result);
            end
            next_cycle();
        end
        reset     = 1'b0;
        bus.valid = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.ready !== 1'b0 || bus.result !== 32'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got ready=%b result=%h want 0/00000000", bus.ready, bus.result);
        end
        $display("txn reset done");
        next_cycle();
    endtask

    task automatic test_function;
        logic        exp_rdy;
        logic [31:0] exp_res;
        tv_enc[0] = 1'b1; tv_rs1[0] = 32'h00000100; tv_rs2[0] = 32'h53100000; tv_exp[0] = 32'hedca7c63;
        tv_enc[1] = 1'b0; tv_rs1[1] = 32'h00007c63; tv_rs2[1] = 32'hedca0000; tv_exp[1] = 32'h53100100;
        tv_enc[2] = 1'b1; tv_rs1[2] = 32'haaaa1100; tv_rs2[2] = 32'h3322bbbb; tv_exp[2] = 32'hc3938263;
        tv_enc[3] = 1'b0; tv_rs1[3] = 32'hffffffff; tv_rs2[3] = 32'hffffffff; tv_exp[3] = 32'h7d7d7d7d;
        for (int v = 0; v < 4; v++) begin
            bus.valid = 1'b1;
            bus.enc   = tv_enc[v];
            bus.rs1   = tv_rs1[v];
            bus.rs2   = tv_rs2[v];
            for (int k = 0; k <= 5; k++) begin
                @(negedge clock);
                exp_rdy = (k == 5);
                exp_res = (k == 5) ? tv_exp[v] : 32'h0;
                checks++;
                if (bus.ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL func%0d_ready T+%0d: got %b want %b", v, k, bus.ready, exp_rdy);
                end
                checks++;
                if (bus.result !== exp_res) begin
                    errors++;
                    $display("FAIL func%0d_result T+%0d: got %h want %h", v, k, bus.result, exp_res);
                end
                next_cycle();
            end
            bus.valid = 1'b0;
            $display("txn func%0d enc=%b rs1=%h rs2=%h expect=%h", v, tv_enc[v], tv_rs1[v], tv_rs2[v], tv_exp[v]);
        end
    endtask

    task automatic test_hold_operands;
        bus.valid = 1'b1;
        bus.enc   = 1'b1;
        bus.rs1   = 32'hffffffff;
        bus.rs2   = 32'hffffffff;
        for (int k = 0; k <= 5; k++) begin
            if (k >= 1) begin
                bus.rs1 = $urandom;
                bus.rs2 = $urandom;
                bus.enc = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            checks++;
            if (bus.ready !== (k == 5)) begin
                errors++;
                $display("FAIL hold_ready T+%0d: got %b want %b", k, bus.ready, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (bus.result !== 32'h16161616) begin
                    errors++;
                    $display("FAIL hold_result T+5: got %h want 16161616", bus.result);
                end
            end
            next_cycle();
        end
        bus.valid = 1'b0;
        $display("txn hold_operands enc=1 all-ff expect=16161616");
    endtask

    task automatic test_abort;
        logic        exp_rdy;
        logic [31:0] exp_res;
        // Abort in BUSY, then restart from IDLE.
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) begin
                bus.valid = 1'b1; bus.enc = 1'b1;
                bus.rs1 = 32'h00000100; bus.rs2 = 32'h53100000;
            end
            if (k == 2) bus.valid = 1'b0;
            if (k == 4) begin
                bus.valid = 1'b1; bus.enc = 1'b0;
                bus.rs1 = 32'h00007c63; bus.rs2 = 32'hedca0000;
            end
            @(negedge clock);
            exp_rdy = (k == 9);
            exp_res = (k == 9) ? 32'h53100100 : 32'h0;
            checks++;
            if (bus.ready !== exp_rdy) begin
                errors++;
                $display("FAIL abort_busy_ready T+%0d: got %b want %b", k, bus.ready, exp_rdy);
            end
            checks++;
            if (bus.result !== exp_res) begin
                errors++;
                $display("FAIL abort_busy_result T+%0d: got %h want %h", k, bus.result, exp_res);
            end
            next_cycle();
        end
        bus.valid = 1'b0;
        $display("txn abort_in_busy then restart expect=53100100");
        next_cycle();
        // Abort in the DONE cycle: ready must not assert.
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) begin
                bus.valid = 1'b1; bus.enc = 1'b1;
                bus.rs1 = 32'haaaa1100; bus.rs2 = 32'h3322bbbb;
            end
            if (k == 5) bus.valid = 1'b0;
            @(negedge clock);
            checks++;
            if (bus.ready !== 1'b0 || bus.result !== 32'h0) begin
                errors++;
                $display("FAIL abort_done T+%0d: got ready=%b result=%h want 0/00000000", k, bus.ready, bus.result);
            end
            next_cycle();
        end
        $display("txn abort_in_done");
    endtask

    task automatic test_reset_mid;
        logic        exp_rdy;
        logic [31:0] exp_res;
        bus.valid = 1'b1; bus.enc = 1'b1;
        bus.rs1 = 32'haaaa1100; bus.rs2 = 32'h3322bbbb;
        for (int k = 0; k <= 9; k++) begin
            reset = (k == 3);
            @(negedge clock);
            exp_rdy = (k == 9);
            exp_res = (k == 9) ? 32'hc3938263 : 32'h0;
            checks++;
            if (bus.ready !== exp_rdy) begin
                errors++;
                $display("FAIL reset_mid_ready T+%0d: got %b want %b", k, bus.ready, exp_rdy);
            end
            checks++;
            if (bus.result !== exp_res) begin
                errors++;
                $display("FAIL reset_mid_result T+%0d: got %h want %h", k, bus.result, exp_res);
            end
            next_cycle();
        end
        reset     = 1'b0;
        bus.valid = 1'b0;
        $display("txn reset_mid_operation expect=c3938263 at T+9");
    endtask

    task automatic test_back_to_back;
        logic        exp_rdy;
        logic [31:0] exp_res;
        bus.valid = 1'b1; bus.enc = 1'b1;
        bus.rs1 = 32'h00000100; bus.rs2 = 32'h53100000;
        for (int k = 0; k <= 11; k++) begin
            if (k == 6) begin
                bus.rs1 = 32'haaaa1100; bus.rs2 = 32'h3322bbbb;
            end
            @(negedge clock);
            exp_rdy = (k == 5) || (k == 11);
            exp_res = (k == 5) ? 32'hedca7c63 : ((k == 11) ? 32'hc3938263 : 32'h0);
            checks++;
            if (bus.ready !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_ready T+%0d: got %b want %b", k, bus.ready, exp_rdy);
            end
            checks++;
            if (bus.result !== exp_res) begin
                errors++;
                $display("FAIL b2b_result T+%0d: got %h want %h", k, bus.result, exp_res);
            end
            next_cycle();
        end
        bus.valid = 1'b0;
        $display("txn back_to_back expect=edca7c63 then c3938263");
    endtask

    initial begin
        reset     = 1'b1;
        bus.valid = 1'b0;
        bus.enc   = 1'b0;
        bus.rs1   = 32'h0;
        bus.rs2   = 32'h0;
        test_reset();
        test_function();
        test_hold_operands();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
